// File: rtl/cte_pkg.sv
// Shared constants for the colour-transform engine:
// Q8 coefficients, rounding, clamp bounds, byte order.
package cte_pkg;

  typedef logic signed [17:0] acc_t;

  localparam acc_t KY_R = 18'sd77;
  localparam acc_t KY_G = 18'sd150;
  localparam acc_t KY_B = 18'sd29;

  localparam acc_t KU_R = -18'sd43;
  localparam acc_t KU_G = -18'sd85;
  localparam acc_t KU_B = 18'sd128;

  localparam acc_t KV_R = 18'sd128;
  localparam acc_t KV_G = -18'sd107;
  localparam acc_t KV_B = -18'sd21;

  localparam acc_t RND = 18'sd128;

  localparam acc_t Y_MIN = 18'sd0;
  localparam acc_t Y_MAX = 18'sd255;
  localparam acc_t C_MIN = -18'sd128;
  localparam acc_t C_MAX = 18'sd127;

  localparam logic [1:0] IDX_U  = 2'd0;
  localparam logic [1:0] IDX_Y0 = 2'd1;
  localparam logic [1:0] IDX_V  = 2'd2;
  localparam logic [1:0] IDX_Y1 = 2'd3;

  // Zero-extend an unsigned component into the signed accumulator
  function automatic acc_t ext(input logic [7:0] c);
    return acc_t'({10'd0, c});
  endfunction

  // Saturate to [lo,hi] and keep the low byte
  function automatic logic [7:0] sat(
    input acc_t v,
    input acc_t lo,
    input acc_t hi
  );
    acc_t t;
    if (v < lo)
      t = lo;
    else if (v > hi)
      t = hi;
    else
      t = v;
    return 8'(t);
  endfunction

endpackage

// File: rtl/cte_rgb2yuv_enc_if.sv
// Pixel-in / byte-out bundle of the RGB->YUV encoder.
// slave = encoder side, master = pixel source / byte sink.
interface cte_rgb2yuv_enc_if;

  logic        in_en;
  logic [23:0] rgb_in;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;

  modport slave (
    input  in_en,
    input  rgb_in,
    output busy,
    output out_valid,
    output yuv_out
  );

  modport master (
    output in_en,
    output rgb_in,
    input  busy,
    input  out_valid,
    input  yuv_out
  );

endinterface

// File: rtl/cte_rgb2yuv_conv.sv
// Combinational RGB -> Y/U/V in Q8 with rounding,
// saturation and optional offset-binary chroma.
module cte_rgb2yuv_conv
  import cte_pkg::*;
#(
  parameter int UV_OFFSET = 0
) (
  input  logic [23:0] rgb,
  output logic [7:0]  y,
  output logic [7:0]  u,
  output logic [7:0]  v
);

  localparam logic [7:0] UV_OFF8 = 8'(UV_OFFSET);

  acc_t r, g, b;
  acc_t sy, su, sv;
  acc_t qy, qu, qv;
  logic [7:0] uc, vc;

  // Weighted sums, arithmetic shift, clamp, chroma offset
  always_comb begin
    r  = ext(rgb[23:16]);
    g  = ext(rgb[15:8]);
    b  = ext(rgb[7:0]);
    sy = KY_R * r + KY_G * g + KY_B * b + RND;
    su = KU_R * r + KU_G * g + KU_B * b + RND;
    sv = KV_R * r + KV_G * g + KV_B * b + RND;
    qy = sy >>> 8;
    qu = su >>> 8;
    qv = sv >>> 8;
    y  = sat(qy, Y_MIN, Y_MAX);
    uc = sat(qu, C_MIN, C_MAX);
    vc = sat(qv, C_MIN, C_MAX);
    u  = uc + UV_OFF8;
    v  = vc + UV_OFF8;
  end

endmodule

// File: rtl/cte_rgb2yuv_enc.sv
// RGB -> 4:2:2 byte-stream encoder (U0,Y0,V0,Y1 per pair).
// Stage C, pair buffer, 4-byte serializer and busy logic.
module cte_rgb2yuv_enc
  import cte_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int UV_OFFSET = 0
) (
  input  logic               clk,
  input  logic               reset,
  cte_rgb2yuv_enc_if.slave   bus
);

  logic [7:0] conv_y, conv_u, conv_v;

  logic             parity;
  logic             cv_valid;
  logic             cv_odd;
  logic [PIX_W-1:0] cv_y, cv_u, cv_v;

  logic [PIX_W-1:0] pb [4];
  logic             pb_full;

  logic [PIX_W-1:0] sh [4];
  logic [1:0]       cnt;
  logic             active;

  logic busy;
  logic accept;
  logic load;

  cte_rgb2yuv_conv #(
    .UV_OFFSET (UV_OFFSET)
  ) u_conv (
    .rgb (bus.rgb_in),
    .y   (conv_y),
    .u   (conv_u),
    .v   (conv_v)
  );

  // Back-pressure: full pair waiting, or odd pixel about to fill it
  always_comb begin
    busy   = pb_full | (cv_valid & cv_odd);
    accept = bus.in_en & ~busy;
    load   = pb_full & (~active | (cnt == 2'd3));
  end

  // Stage C: register converted pixel and its parity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity   <= 1'b0;
      cv_valid <= 1'b0;
      cv_odd   <= 1'b0;
      cv_y     <= '0;
      cv_u     <= '0;
      cv_v     <= '0;
    end else begin
      cv_valid <= accept;
      if (accept) begin
        cv_y   <= conv_y;
        cv_u   <= conv_u;
        cv_v   <= conv_v;
        cv_odd <= parity;
        parity <= ~parity;
      end
    end
  end

  // Pair buffer: even pixel gives U,Y0,V; odd gives Y1 and completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        pb[i] <= '0;
      pb_full <= 1'b0;
    end else begin
      if (cv_valid && !cv_odd) begin
        pb[IDX_U]  <= cv_u;
        pb[IDX_Y0] <= cv_y;
        pb[IDX_V]  <= cv_v;
      end
      if (cv_valid && cv_odd) begin
        pb[IDX_Y1] <= cv_y;
        pb_full    <= 1'b1;
      end else if (load) begin
        pb_full <= 1'b0;
      end
    end
  end

  // Serializer: reload on the last byte so pairs run gap-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        sh[i] <= '0;
      cnt    <= 2'd0;
      active <= 1'b0;
    end else if (load) begin
      sh     <= pb;
      cnt    <= 2'd0;
      active <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3)
        active <= 1'b0;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.busy      = busy;
    bus.out_valid = active;
    bus.yuv_out   = active ? sh[cnt] : 8'h00;
  end

endmodule

// File: tb/tb_cte_rgb2yuv_enc.sv
// Scoreboard bench for cte_rgb2yuv_enc: two instances,
// UV_OFFSET=0 (a) and UV_OFFSET=128 (b).
module tb_cte_rgb2yuv_enc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cte_rgb2yuv_enc_if ifa();
  cte_rgb2yuv_enc_if ifb();

  cte_rgb2yuv_enc #(
    .PIX_W     (8),
    .UV_OFFSET (0)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  cte_rgb2yuv_enc #(
    .PIX_W     (8),
    .UV_OFFSET (128)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] ea, eb;

  int   rise_a = -1;
  int   run_a = 0;
  int   last_run_a = 0;
  logic prev_a = 1'b0;

  int k, acc, nv, idx, n;
  logic bsy;
  logic [23:0] px4 [8];
  logic [7:0]  by4 [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit sel, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      if (sel) qb.push_back(w[i*8 +: 8]);
      else     qa.push_back(w[i*8 +: 8]);
    end
  endtask

  task automatic send(input bit sel, input logic [23:0] px,
                      output int a);
    int m = 0;
    if (sel) begin ifb.in_en = 1'b1; ifb.rgb_in = px; end
    else     begin ifa.in_en = 1'b1; ifa.rgb_in = px; end
    while ((sel ? ifb.busy : ifa.busy) && m < 50) begin
      @(posedge clk); #1;
      m++;
    end
    if (m >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: busy stuck, px %06h", px);
    end
    @(posedge clk); #1;
    a = cyc;
  endtask

  task automatic wait_idle(input bit sel);
    int m = 0;
    while (m < 300 &&
           ((sel ? qb.size() : qa.size()) != 0 ||
            (sel ? ifb.out_valid : ifa.out_valid))) begin
      @(posedge clk); #1;
      m++;
    end
    if (m >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: dut %0d left %0d bytes",
               sel, sel ? qb.size() : qa.size());
    end
  endtask

  // Monitor a: compare each presented byte, track bursts
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.out_valid) begin
        if (!prev_a) begin
          rise_a = cyc;
          run_a = 0;
        end
        run_a++;
        last_run_a = run_a;
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_extra_byte: got %02h expected none",
                   ifa.yuv_out);
        end else begin
          ea = qa.pop_front();
          chk("a_byte", 32'(ifa.yuv_out), 32'(ea));
        end
      end
      prev_a = ifa.out_valid;
    end else begin
      prev_a = 1'b0;
    end
  end

  // Monitor b: compare each presented byte
  always @(negedge clk) begin
    if (!reset && ifb.out_valid) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_extra_byte: got %02h expected none",
                 ifb.yuv_out);
      end else begin
        eb = qb.pop_front();
        chk("b_byte", 32'(ifb.yuv_out), 32'(eb));
      end
    end
  end

  initial begin
    ifa.in_en = 1'b0; ifa.rgb_in = '0;
    ifb.in_en = 1'b0; ifb.rgb_in = '0;

    px4 = '{24'hFFFFFF, 24'hFFFFFF,
            24'hFF0000, 24'h000000,
            24'h0000FF, 24'hFFFFFF,
            24'h00FF00, 24'h808080};
    by4 = '{8'h00, 8'hFF, 8'h00, 8'hFF,
            8'hD5, 8'h4D, 8'h7F, 8'h00,
            8'h7F, 8'h1D, 8'hEB, 8'hFF,
            8'hAB, 8'h95, 8'h95, 8'h80};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", 32'(ifa.busy), 0);
    chk("rst_a_valid", 32'(ifa.out_valid), 0);
    chk("rst_a_byte", 32'(ifa.yuv_out), 0);
    chk("rst_b_busy", 32'(ifb.busy), 0);
    chk("rst_b_valid", 32'(ifb.out_valid), 0);
    chk("rst_b_byte", 32'(ifb.yuv_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: white pair, latency and burst length
    rise_a = -1;
    push(0, 32'h00FF00FF);
    send(0, 24'hFFFFFF, k);
    send(0, 24'hFFFFFF, acc);
    ifa.in_en = 1'b0;
    wait_idle(0);
    chk("t1_first_valid_cyc", 32'(rise_a), 32'(k + 3));
    chk("t1_valid_cycles", 32'(last_run_a), 4);

    // 2: red + black, V saturates
    push(0, 32'hD54D7F00);
    send(0, 24'hFF0000, acc);
    send(0, 24'h000000, acc);
    ifa.in_en = 1'b0;
    wait_idle(0);

    // 3: blue + white, U saturates
    push(0, 32'h7F1DEBFF);
    send(0, 24'h0000FF, acc);
    send(0, 24'hFFFFFF, acc);
    ifa.in_en = 1'b0;
    wait_idle(0);

    // 4: continuous in_en, 8 pixels
    for (int i = 0; i < 16; i++) qa.push_back(by4[i]);
    idx = 0;
    ifa.in_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bsy = ifa.busy;
      chk("t4_busy", 32'(bsy), 32'((c % 4) >= 2));
      ifa.rgb_in = px4[idx < 8 ? idx : 7];
      @(posedge clk); #1;
      if (!bsy) idx++;
    end
    ifa.in_en = 1'b0;
    chk("t4_accepted", 32'(idx), 8);
    wait_idle(0);
    chk("t4_gapless_run", 32'(last_run_a), 16);

    // 5: reset mid-stream with a lone even pending
    rise_a = -1;
    push(0, 32'h00FF00FF);
    send(0, 24'hFFFFFF, acc);
    send(0, 24'hFFFFFF, acc);
    send(0, 24'hFF0000, acc);
    ifa.in_en = 1'b0;
    n = 0;
    while ((rise_a < 0 || cyc < rise_a + 2) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_saw_output", 32'(rise_a >= 0), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(ifa.out_valid), 0);
    chk("t5_rst_byte", 32'(ifa.yuv_out), 0);
    chk("t5_rst_busy", 32'(ifa.busy), 0);
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push(0, 32'h00FF00FF);
    send(0, 24'hFFFFFF, acc);
    send(0, 24'hFFFFFF, acc);
    ifa.in_en = 1'b0;
    wait_idle(0);

    // 6: offset-binary chroma, then a lone even pixel
    push(1, 32'h80FF80FF);
    send(1, 24'hFFFFFF, acc);
    send(1, 24'hFFFFFF, acc);
    ifb.in_en = 1'b0;
    wait_idle(1);
    send(1, 24'h123456, acc);
    ifb.in_en = 1'b0;
    nv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nv += int'(ifb.out_valid);
    end
    chk("t6_lone_valid_cycles", 32'(nv), 0);
    chk("t6_lone_busy", 32'(ifb.busy), 0);

    chk("qa_left", 32'(qa.size()), 0);
    chk("qb_left", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
